hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Multi-cycle multiply/divide unit that holds the HI/LO architectural registers.
- Sits in the EX stage of the pipelined CPU. It is driven by the decoder's hi/lo control fields: operation code, unsigned flag and HI/LO write-target select.
- Successor to the fixed-latency mult/div unit: width and latencies are parametrised, it adds multiply-accumulate modes (madd/maddu/msub/msubu), and it adds a cancel input for pipeline flush.
- `busy`/`start` feed the hazard unit, which stalls hi/lo-touching instructions in D.

Parameters:
- DATA_W, 32, operand width and width of HI and LO.
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu; must be at least 1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be at least 1.
- CNT_W, 4, countdown counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch the operation in `op`; single-cycle pulse from EX.
- op  in  4  operation code (hlu_op_t).
- src_a  in  DATA_W  rs operand.
- src_b  in  DATA_W  rt operand.
- hl_write  in  1  mthi/mtlo write strobe.
- hl_dst  in  1  write target: 1 = HI, 0 = LO.
- cancel  in  1  flush; abort the in-flight operation.
- busy  out  1  operation in flight.
- hi  out  DATA_W  architectural HI.
- lo  out  DATA_W  architectural LO.

Behaviour:
- Reset (synchronous, active-high) has priority over all inputs. On the next edge: hi=0, lo=0, busy=0, state IDLE, count=0, pending result discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN on a clock edge with start=1 and op not equal to HLU_NONE:
  - Latch the computed result into pend_hi/pend_lo.
  - Load count with MULT_CYCLES or DIV_CYCLES.
  - busy rises in the cycle after start, so the hazard unit uses `start | busy`.
- In RUN, count decrements each edge. The edge on which count==1 does three things together: hi/lo take pend_hi/pend_lo, busy=0, state returns to IDLE. busy is therefore high for exactly N cycles.
- Arithmetic, computed from operands sampled at start, with full 2*DATA_W product:
  - mult: {hi,lo} = signed(a) * signed(b).
  - multu: {hi,lo} = unsigned(a) * unsigned(b).
  - madd/maddu: {hi,lo} = {hi,lo} + product (signed or unsigned per op), wrapping modulo 2^(2*DATA_W).
  - msub/msubu: {hi,lo} = {hi,lo} - product (signed or unsigned per op), same wrapping.
  - The accumulate base is the HI/LO value at the start edge.
  - div: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - divu: same outputs, unsigned.
  - Signed MIN / -1: lo = MIN, hi = 0.
  - Divide by zero: busy timing is unchanged; hi and lo are left unchanged at completion.
- hl_write: when not busy, writes src_a into the register selected by hl_dst on that edge.
- Ignored inputs (hazard unit guarantees these never happen; unit must still be safe):
  - start while busy=1.
  - hl_write while busy=1.
  - start and hl_write in the same cycle: start wins and hl_write is dropped.
- cancel=1:
  - Forces IDLE and busy=0 on that edge. The pending result is discarded; hi/lo keep their pre-operation values.
  - cancel together with start suppresses the launch.
  - cancel on the completion edge: the commit is suppressed.
  - cancel does not block hl_write issued in the same cycle.
- op values outside the defined set behave as HLU_NONE.

Decomposition:
- Shared package hlu_pkg holds:
  - hlu_op_t, 4 bits: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8.
  - State enum: IDLE / RUN.
  - Default latency constants.
- The decoder imports hlu_op_t so its hluControl/hluUnsigned pair is replaced by a single op field.
- One natural sub-module: hlu_arith, combinational. It takes op, a, b, {hi,lo} and produces the next {hi,lo} plus a div_by_zero flag. hilo_unit keeps the FSM, counter and registers.

Test Plan:
- Signed multiply: reset, then start op=MULT with a=32'hFFFFFFFE (-2), b=3. Expect busy high for exactly 5 cycles starting the cycle after start; on the following edge hi=FFFFFFFF, lo=FFFFFFFA.
- Unsigned vs signed divide:
  - op=DIVU, a=7, b=2: after 10 busy cycles, lo=3, hi=1.
  - op=DIV, a=-7, b=2: lo=FFFFFFFD, hi=FFFFFFFF.
- Accumulate and divide by zero:
  - mthi 0, mtlo 10, then MADD with a=4, b=5: lo=30, hi=0.
  - Then MSUBU with a=1, b=31: {hi,lo}=FFFFFFFF_FFFFFFFF.
  - DIV with b=0: hi/lo unchanged, busy still 10 cycles.
- Signed overflow: DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- Cancel and reset:
  - Assert cancel in the 3rd busy cycle of MULT: busy drops next edge; hi/lo keep old values.
  - Separately, assert reset mid-DIV: hi=lo=0, busy=0 on the next edge.
- Illegal concurrency:
  - start while busy: no effect on the count or the result.
  - hl_write while busy: ignored.
  - start and hl_write in the same cycle: only the operation takes effect.

Source files
------------

// File: rtl/hlu_pkg.sv
// Shared HI/LO unit types: operation codes, FSM states and default latencies.
// Imported by the decoder, the arithmetic datapath and the HI/LO unit itself.
package hlu_pkg;

  typedef enum logic [3:0] {
    HLU_NONE  = 4'd0,
    HLU_MULT  = 4'd1,
    HLU_MULTU = 4'd2,
    HLU_DIV   = 4'd3,
    HLU_DIVU  = 4'd4,
    HLU_MADD  = 4'd5,
    HLU_MADDU = 4'd6,
    HLU_MSUB  = 4'd7,
    HLU_MSUBU = 4'd8
  } hlu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } hlu_state_t;

  localparam int HLU_DATA_W      = 32;
  localparam int HLU_MULT_CYCLES = 5;
  localparam int HLU_DIV_CYCLES  = 10;
  localparam int HLU_CNT_W       = 4;

  function automatic logic hlu_op_valid(input hlu_op_t op);
    return (op >= HLU_MULT) && (op <= HLU_MSUBU);
  endfunction

  function automatic logic hlu_op_is_div(input hlu_op_t op);
    return (op == HLU_DIV) || (op == HLU_DIVU);
  endfunction

endpackage

// File: rtl/hlu_arith.sv
// Combinational HI/LO datapath: next {hi,lo} for mult/div/accumulate ops, zero latency.
// No flow control; unknown ops and divide-by-zero pass the current {hi,lo} through.
module hlu_arith
  import hlu_pkg::*;
#(
  parameter int DATA_W = HLU_DATA_W
) (
  input  hlu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo,
  output logic              div_by_zero
);

  localparam int PW = 2 * DATA_W;

  logic              sgn;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     acc;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] b_safe;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic              neg_q;
  logic              neg_r;

  always_comb begin
    sgn = (op == HLU_MULT) || (op == HLU_MADD) || (op == HLU_MSUB) || (op == HLU_DIV);

    // Extending to the full product width makes a plain multiply exact modulo 2^PW
    a_ext = sgn ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    b_ext = sgn ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    prod  = a_ext * b_ext;
    acc   = {hi, lo};

    // Signed divide runs on magnitudes; MIN/-1 wraps back to MIN with remainder 0
    a_mag       = (sgn && a[DATA_W-1]) ? -a : a;
    b_mag       = (sgn && b[DATA_W-1]) ? -b : b;
    div_by_zero = hlu_op_is_div(op) && (b == '0);
    b_safe      = (b == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : b_mag;
    q_mag       = a_mag / b_safe;
    r_mag       = a_mag % b_safe;
    neg_q       = sgn && (a[DATA_W-1] ^ b[DATA_W-1]);
    neg_r       = sgn && a[DATA_W-1];
    quot        = neg_q ? -q_mag : q_mag;
    rem         = neg_r ? -r_mag : r_mag;

    {res_hi, res_lo} = acc;
    case (op)
      HLU_MULT, HLU_MULTU: {res_hi, res_lo} = prod;
      HLU_MADD, HLU_MADDU: {res_hi, res_lo} = acc + prod;
      HLU_MSUB, HLU_MSUBU: {res_hi, res_lo} = acc - prod;
      HLU_DIV, HLU_DIVU: begin
        if (!div_by_zero) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: {res_hi, res_lo} = acc;
    endcase
  end

endmodule

// File: rtl/hilo_unit.sv
// Multi-cycle mult/div unit owning HI/LO; result lands MULT_CYCLES/DIV_CYCLES edges after start.
// No backpressure: busy (with start) stalls hi/lo users upstream; start/hl_write while busy are dropped.
module hilo_unit
  import hlu_pkg::*;
#(
  parameter int DATA_W      = HLU_DATA_W,
  parameter int MULT_CYCLES = HLU_MULT_CYCLES,
  parameter int DIV_CYCLES  = HLU_DIV_CYCLES,
  parameter int CNT_W       = HLU_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  hlu_op_t           op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              hl_write,
  input  logic              hl_dst,
  input  logic              cancel,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  hlu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
  logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              div_by_zero;
  logic              launch;

  hlu_arith #(.DATA_W(DATA_W)) u_arith (
    .op          (op),
    .a           (src_a),
    .b           (src_b),
    .hi          (hi_q),
    .lo          (lo_q),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    launch    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch = start && hlu_op_valid(op) && !cancel;
        if (launch) begin
          state_d   = ST_RUN;
          count_d   = hlu_op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_wr_d = !div_by_zero;
        end else if (hl_write) begin
          if (hl_dst) hi_d = src_a;
          else        lo_d = src_a;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (count_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          count_d = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: expected {hi,lo,busy length} queued at issue, checked on busy fall.
module tb_hilo_unit;
  import hlu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  hlu_op_t     op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hl_write;
  logic        hl_dst;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  int   cyc = 0;
  logic prev_busy = 1'b0;

  hilo_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hl_write (hl_write),
    .hl_dst   (hl_dst),
    .cancel   (cancel),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and compares when busy falls
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      cyc++;
    end else if (prev_busy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got hi=%h lo=%h expected no operation", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("busy_cycles", 32'(cyc), 32'(e.cyc));
      end
      cyc = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input hlu_op_t o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = HLU_NONE;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=%b expected 0 within 40 cycles", busy);
    end
    tick();
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi  = h;
    e.lo  = l;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic run_op(input hlu_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l, input int c);
    push(h, l, c);
    launch(o, a, b);
    wait_idle();
  endtask

  task automatic mt(input logic dst, input logic [31:0] v);
    hl_write = 1'b1;
    hl_dst   = dst;
    src_a    = v;
    tick();
    hl_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = HLU_NONE; src_a = '0; src_b = '0;
    hl_write = 1'b0; hl_dst = 1'b0; cancel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    run_op(HLU_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op(HLU_DIVU,  32'd7,         32'd2, 32'h0000_0001, 32'h0000_0003, 10);
    run_op(HLU_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

    mt(1'b1, 32'd0);
    mt(1'b0, 32'd10);
    run_op(HLU_MADD,  32'd4, 32'd5,  32'h0000_0000, 32'h0000_001E, 5);
    run_op(HLU_MSUBU, 32'd1, 32'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op(HLU_DIV,   32'd5, 32'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 10);
    run_op(HLU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);

    // Cancel in the third busy cycle
    push(32'h0000_0000, 32'h8000_0000, 3);
    launch(HLU_MULT, 32'd2, 32'd3);
    tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    wait_idle();

    // Start while busy must not reload the count
    push(32'hFFFF_FFFE, 32'h0000_0001, 5);
    launch(HLU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    op = HLU_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0; op = HLU_NONE;
    wait_idle();

    // hl_write while busy is ignored (divide by zero leaves hi/lo visible)
    push(32'hFFFF_FFFE, 32'h0000_0001, 10);
    launch(HLU_DIV, 32'd1, 32'd0);
    tick();
    hl_write = 1'b1; hl_dst = 1'b1; src_a = 32'hDEAD_BEEF;
    tick();
    hl_write = 1'b0;
    wait_idle();

    // start with hl_write in the same cycle: write dropped
    push(32'hFFFF_FFFE, 32'h0000_0001, 10);
    hl_write = 1'b1; hl_dst = 1'b0;
    launch(HLU_DIV, 32'h0000_0055, 32'd0);
    hl_write = 1'b0;
    wait_idle();

    run_op(HLU_MSUB,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h0000_0003, 5);
    run_op(HLU_MADDU, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0000_0003, 5);

    // Reset in the middle of a divide
    push(32'h0000_0000, 32'h0000_0000, 2);
    launch(HLU_DIV, 32'd100, 32'd7);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle();

    // cancel together with start suppresses the launch
    cancel = 1'b1;
    launch(HLU_MULT, 32'd9, 32'd9);
    cancel = 1'b0;
    chk("cancel_start_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("cancel_start_lo", lo, 32'h0);

    run_op(HLU_MULT, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 5);
    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
